// File: rtl/count_mod60_pkg.sv
// Shared constants for the modulo-60 BCD counter.
package count_mod60_pkg;
  localparam int DIGIT_W      = 4;  // one BCD digit
  localparam int ONES_MAX_DEF = 9;  // ones digit terminal value
  localparam int TENS_MAX_DEF = 5;  // tens digit terminal value
endpackage

// File: rtl/count_mod60_digit.sv
// Single BCD digit counter: counts 0..MAX when enabled, wraps to 0, and
// raises tc when the next enabled edge will wrap. Any out-of-range value
// (only reachable by forcing) is pulled back to 0 on the next enabled edge.
module bcd_digit_counter
  import count_mod60_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [DIGIT_W-1:0] q,
  output logic               tc
);
  localparam logic [DIGIT_W-1:0] MAX_Q = MAX[DIGIT_W-1:0];

  // Digit register: async clear, advance or wrap on enabled edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (en)
      q <= (q >= MAX_Q) ? '0 : q + {{(DIGIT_W-1){1'b0}}, 1'b1};
  end

  // Terminal count is combinational so a cascaded stage sees it same-cycle
  assign tc = en & (q == MAX_Q);
endmodule

// File: rtl/count_mod60.sv
// Modulo-60 counter from two cascaded BCD digits (ones 0..9, tens 0..5).
// co is high for the single enabled cycle before the 59 -> 00 wrap and is
// meant to drive the en of the next stage in a clock/timer chain.
module count_mod60
  import count_mod60_pkg::*;
#(
  parameter int ONES_MAX = ONES_MAX_DEF,
  parameter int TENS_MAX = TENS_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [DIGIT_W-1:0] count,
  output logic               co,
  output logic [DIGIT_W-1:0] tens
);
  logic ones_tc;

  // Ones digit advances on every enabled edge
  bcd_digit_counter #(.MAX(ONES_MAX)) u_ones (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .q   (count),
    .tc  (ones_tc)
  );

  // Tens digit advances only when the ones digit wraps
  bcd_digit_counter #(.MAX(TENS_MAX)) u_tens (
    .clk (clk),
    .rst (rst),
    .en  (ones_tc),
    .q   (tens),
    .tc  (co)
  );
endmodule

// File: tb/tb_count_mod60.sv
// Self-checking bench for count_mod60: directed table, corner sequences and
// randomized enable/reset traffic against an integer seconds model.
module tb_count_mod60;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] count;
  logic       co;
  logic [3:0] tens;

  int checks = 0;
  int errors = 0;
  int v      = 0;   // model value 0..59
  int co_pulses = 0;
  int exp_pulses = 0;

  count_mod60 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .count (count),
    .co    (co),
    .tens  (tens)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic en;
    int   exp_val;  // tens*10+count after the edge
    logic exp_co;   // co before the edge
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string name, input int val);
    chk({name, "_count"}, int'(count), val % 10);
    chk({name, "_tens"},  int'(tens),  val / 10);
  endtask

  // Called at posedge+1: drive en, check co mid-cycle, clock, check digits
  task automatic cycle(input logic e, input string name);
    en = e;
    #1;
    chk({name, "_co"}, int'(co), (e && v == 59) ? 1 : 0);
    if (co) co_pulses++;
    if (e && v == 59) exp_pulses++;
    @(posedge clk);
    if (e) v = (v + 1) % 60;
    #1;
    chk_state(name, v);
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 60 && v != target; k++) cycle(1'b1, "run");
    chk("run_reached", v, target);
  endtask

  initial begin
    // 5 idle cycles, then 10 enabled cycles from 00
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 0, 1'b0};
    for (int i = 0; i < 10; i++) tbl[5+i] = '{1'b1, i + 1, 1'b0};

    // Power-on reset for 100 ns; clock edges must not disturb it
    rst = 1'b0; en = 1'b0;
    #100;
    chk("por_count", int'(count), 0);
    chk("por_tens",  int'(tens), 0);
    chk("por_co",    int'(co), 0);
    en = 1'b1;
    @(posedge clk); #1;
    chk("rst_dom_count", int'(count), 0);
    chk("rst_dom_co",    int'(co), 0);
    en = 1'b0;
    rst = 1'b1;
    v = 0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en;
      #1;
      chk("tbl_co", int'(co), int'(tbl[i].exp_co));
      @(posedge clk); #1;
      if (tbl[i].en) v = (v + 1) % 60;
      chk_state("tbl", tbl[i].exp_val);
    end

    // Up to 59: co must be high there, then wrap to 00
    run_to(59);
    en = 1'b1; #1;
    chk("co_at_59", int'(co), 1);
    en = 1'b0; #1;
    chk("co_gated_59", int'(co), 0);
    cycle(1'b1, "wrap");
    chk("wrap_val", int'(tens) * 10 + int'(count), 0);

    // Hold at 37 for 4 cycles, then resume to 38
    run_to(37);
    for (int i = 0; i < 4; i++) cycle(1'b0, "hold37");
    cycle(1'b1, "resume38");
    chk("resume_val", int'(tens) * 10 + int'(count), 38);

    // Async reset mid-cycle at 42
    run_to(42);
    en = 1'b1;
    #5;
    rst = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_tens",  int'(tens), 0);
    chk("async_co",    int'(co), 0);
    @(posedge clk); #1;
    chk_state("rst_hold", 0);
    rst = 1'b1;
    v = 0;
    cycle(1'b1, "after_rst1");
    cycle(1'b1, "after_rst2");
    chk("after_rst_val", int'(tens) * 10 + int'(count), 2);

    // Randomized traffic with occasional async reset pulses
    co_pulses = 0; exp_pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #2;
        chk("rnd_rst_count", int'(count), 0);
        chk("rnd_rst_tens",  int'(tens), 0);
        rst = 1'b1;
        v = 0;
      end
      cycle(($urandom_range(0, 3) != 0), "rnd");
    end
    chk("co_pulse_total", co_pulses, exp_pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1);
  end
endmodule
